// File: rtl/mem_wait_pkg.sv
// Shared types and constants for the memory wait-state controller.
// The runtime-latency build option is selected with MEM_WAIT_RUNTIME_LAT_EN.
package mem_wait_pkg;

    localparam int unsigned LAT_CNT_W = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } mws_state_e;

    // A latency of 0 behaves like 1, so the counter load is floored at 0.
    function automatic logic [LAT_CNT_W-1:0] lat_to_cnt(input logic [LAT_CNT_W-1:0] lat);
        logic [LAT_CNT_W-1:0] cnt;
        cnt = '0;
        if (lat != '0) begin
            cnt = LAT_CNT_W'(lat - LAT_CNT_W'(1));
        end
        return cnt;
    endfunction

endpackage : mem_wait_pkg

// File: rtl/mem_wait_state_ctrl.sv
// Inserts fixed read wait states between an AXI adapter and a simple SRAM-style memory.
// Define MEM_WAIT_RUNTIME_LAT_EN to add cfg_lat_i, which overrides RD_LATENCY per read.
module mem_wait_state_ctrl
    import mem_wait_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 10,
    parameter int unsigned RD_LATENCY     = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
`ifdef MEM_WAIT_RUNTIME_LAT_EN
    input  logic [LAT_CNT_W-1:0]          cfg_lat_i,
`endif
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   be_i,
    input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
    input  logic [AXI_USER_WIDTH-1:0]     user_i,
    output logic [AXI_DATA_WIDTH-1:0]     rdata_o,
    output logic [AXI_USER_WIDTH-1:0]     ruser_o,
    output logic                          rdata_valid_o,
    output logic                          busy_o,
    output logic                          drop_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [AXI_ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [AXI_DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [AXI_DATA_WIDTH-1:0]     mem_rdata_i
);

    localparam logic [LAT_CNT_W-1:0] STATIC_LAT = LAT_CNT_W'(RD_LATENCY);

    mws_state_e                  state_q, state_d;
    logic [LAT_CNT_W-1:0]        cnt_q, cnt_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [AXI_USER_WIDTH-1:0]   ruser_q, ruser_d;
    logic [LAT_CNT_W-1:0]        lat_sel;

`ifdef MEM_WAIT_RUNTIME_LAT_EN
    assign lat_sel = cfg_lat_i;
`else
    assign lat_sel = STATIC_LAT;
`endif

    // Write/address path is a straight wire; only the request strobe is gated by state.
    assign mem_we_o    = we_i;
    assign mem_addr_o  = addr_i;
    assign mem_be_o    = be_i;
    assign mem_wdata_o = wdata_i;
    assign ruser_o     = ruser_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            ruser_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ruser_q <= ruser_d;
        end
    end

    // Next state; the return cycle forwards mem_rdata_i directly and captures it.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        ruser_d       = ruser_q;
        mem_req_o     = 1'b0;
        rdata_valid_o = 1'b0;
        busy_o        = 1'b0;
        drop_o        = 1'b0;
        rdata_o       = rdata_q;

        case (state_q)
            IDLE: begin
                mem_req_o = req_i;
                if (req_i && !we_i) begin
                    ruser_d = user_i;
                    cnt_d   = lat_to_cnt(lat_sel);
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                busy_o = 1'b1;
                drop_o = req_i;
                if (cnt_q == '0) begin
                    rdata_valid_o = 1'b1;
                    rdata_o       = mem_rdata_i;
                    rdata_d       = mem_rdata_i;
                    state_d       = IDLE;
                end else begin
                    cnt_d = LAT_CNT_W'(cnt_q - LAT_CNT_W'(1));
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule : mem_wait_state_ctrl

// File: tb/tb_mem_wait_state_ctrl.sv
// Directed bench for mem_wait_state_ctrl: four instances at RD_LATENCY 3, 2, 4 and 1.
module tb_mem_wait_state_ctrl;

    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 64;
    localparam int unsigned UW  = 10;
    localparam int unsigned BW  = DW / 8;
    localparam int unsigned LATS [4] = '{3, 2, 4, 1};
    localparam int I3 = 0;
    localparam int I2 = 1;
    localparam int I4 = 2;
    localparam int I1 = 3;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic [UW-1:0] user;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] rdata       [4];
    logic [UW-1:0] ruser       [4];
    logic          rvalid      [4];
    logic          busy        [4];
    logic          drop        [4];
    logic          mem_req     [4];
    logic          mem_we      [4];
    logic [AW-1:0] mem_addr    [4];
    logic [BW-1:0] mem_be      [4];
    logic [DW-1:0] mem_wdata   [4];
`ifdef MEM_WAIT_RUNTIME_LAT_EN
    logic [3:0]    cfg_lat     [4];
`endif

    int n_chk  = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_wait_state_ctrl #(
            .AXI_ADDR_WIDTH (AW),
            .AXI_DATA_WIDTH (DW),
            .AXI_USER_WIDTH (UW),
            .RD_LATENCY     (LATS[g])
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
`ifdef MEM_WAIT_RUNTIME_LAT_EN
            .cfg_lat_i     (cfg_lat[g]),
`endif
            .req_i         (req),
            .we_i          (we),
            .addr_i        (addr),
            .be_i          (be),
            .wdata_i       (wdata),
            .user_i        (user),
            .rdata_o       (rdata[g]),
            .ruser_o       (ruser[g]),
            .rdata_valid_o (rvalid[g]),
            .busy_o        (busy[g]),
            .drop_o        (drop[g]),
            .mem_req_o     (mem_req[g]),
            .mem_we_o      (mem_we[g]),
            .mem_addr_o    (mem_addr[g]),
            .mem_be_o      (mem_be[g]),
            .mem_wdata_o   (mem_wdata[g]),
            .mem_rdata_i   (mem_rdata)
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Each cycle: inputs change 2 time units after the rising edge, outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [UW-1:0] u);
        req  = r;
        we   = w;
        addr = a;
        user = u;
        #1;
    endtask

    task automatic do_reset();
        tick();
        drive(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 1'b0;
        we        = 1'b0;
        addr      = '0;
        be        = '0;
        wdata     = '0;
        user      = '0;
        mem_rdata = '0;
`ifdef MEM_WAIT_RUNTIME_LAT_EN
        for (int i = 0; i < 4; i++) cfg_lat[i] = 4'(LATS[i]);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // Reset state
        chk("rst_rvalid", 64'(rvalid[I3]), 64'd0);
        chk("rst_busy",   64'(busy[I3]),   64'd0);
        chk("rst_drop",   64'(drop[I3]),   64'd0);
        chk("rst_rdata",  64'(rdata[I3]),  64'd0);
        chk("rst_ruser",  64'(ruser[I3]),  64'd0);

        // Read with latency 3
        do_reset();
        tick(); drive(1'b1, 1'b0, 64'h1000, 10'h005);
        chk("l3_c0_req",  64'(mem_req[I3]),  64'd1);
        chk("l3_c0_addr", 64'(mem_addr[I3]), 64'h1000);
        chk("l3_c0_busy", 64'(busy[I3]),     64'd0);
        tick(); drive(1'b0, 1'b0, '0, '0);
        chk("l3_c1_req",  64'(mem_req[I3]), 64'd0);
        chk("l3_c1_busy", 64'(busy[I3]),    64'd1);
        chk("l3_c1_vld",  64'(rvalid[I3]),  64'd0);
        tick(); drive(1'b0, 1'b0, '0, '0);
        chk("l3_c2_busy", 64'(busy[I3]),    64'd1);
        chk("l3_c2_vld",  64'(rvalid[I3]),  64'd0);
        tick(); mem_rdata = 64'hDEADBEEF; drive(1'b0, 1'b0, '0, '0);
        chk("l3_c3_vld",   64'(rvalid[I3]), 64'd1);
        chk("l3_c3_busy",  64'(busy[I3]),   64'd1);
        chk("l3_c3_rdata", 64'(rdata[I3]),  64'hDEADBEEF);
        chk("l3_c3_ruser", 64'(ruser[I3]),  64'h5);
        tick(); mem_rdata = 64'h1234; drive(1'b0, 1'b0, '0, '0);
        chk("l3_c4_vld",   64'(rvalid[I3]), 64'd0);
        chk("l3_c4_busy",  64'(busy[I3]),   64'd0);
        chk("l3_c4_hold",  64'(rdata[I3]),  64'hDEADBEEF);

        // Back-to-back writes
        do_reset();
        be = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick(); wdata = 64'(i + 16); drive(1'b1, 1'b1, 64'(i * 8), '0);
            chk("wr_req",   64'(mem_req[I3]),   64'd1);
            chk("wr_we",    64'(mem_we[I3]),    64'd1);
            chk("wr_addr",  64'(mem_addr[I3]),  64'(i * 8));
            chk("wr_be",    64'(mem_be[I3]),    64'hFF);
            chk("wr_wdata", 64'(mem_wdata[I3]), 64'(i + 16));
            chk("wr_busy",  64'(busy[I3]),      64'd0);
            chk("wr_vld",   64'(rvalid[I3]),    64'd0);
        end
        tick(); drive(1'b0, 1'b0, '0, '0);
        chk("wr_end_req",  64'(mem_req[I3]), 64'd0);
        chk("wr_end_vld",  64'(rvalid[I3]),  64'd0);
        chk("wr_end_busy", 64'(busy[I3]),    64'd0);
        be = '0;

        // Latency 2: drop while waiting and on the return cycle
        do_reset();
        tick(); drive(1'b1, 1'b0, 64'h40, 10'h011);
        chk("l2_c0_req", 64'(mem_req[I2]), 64'd1);
        tick(); drive(1'b1, 1'b0, 64'h48, 10'h022);
        chk("l2_c1_drop", 64'(drop[I2]),    64'd1);
        chk("l2_c1_req",  64'(mem_req[I2]), 64'd0);
        chk("l2_c1_vld",  64'(rvalid[I2]),  64'd0);
        tick(); mem_rdata = 64'hCAFE; drive(1'b0, 1'b0, '0, '0);
        chk("l2_c2_vld",   64'(rvalid[I2]), 64'd1);
        chk("l2_c2_drop",  64'(drop[I2]),   64'd0);
        chk("l2_c2_rdata", 64'(rdata[I2]),  64'hCAFE);
        chk("l2_c2_ruser", 64'(ruser[I2]),  64'h011);
        tick(); drive(1'b1, 1'b0, 64'h50, 10'h033);
        chk("l2_c3_req",  64'(mem_req[I2]), 64'd1);
        chk("l2_c3_busy", 64'(busy[I2]),    64'd0);
        tick(); drive(1'b0, 1'b0, '0, '0);
        chk("l2_c4_busy", 64'(busy[I2]),    64'd1);
        tick(); mem_rdata = 64'hBEEF; drive(1'b1, 1'b0, 64'h58, 10'h044);
        chk("l2_c5_vld",  64'(rvalid[I2]),  64'd1);
        chk("l2_c5_drop", 64'(drop[I2]),    64'd1);
        chk("l2_c5_req",  64'(mem_req[I2]), 64'd0);
        chk("l2_c5_ruser", 64'(ruser[I2]),  64'h033);
        tick(); drive(1'b0, 1'b0, '0, '0);
        chk("l2_c6_busy", 64'(busy[I2]),   64'd0);
        chk("l2_c6_drop", 64'(drop[I2]),   64'd0);
        chk("l2_c6_hold", 64'(rdata[I2]),  64'hBEEF);

        // Latency 4: reset in the middle of a read
        do_reset();
        mem_rdata = 64'h0;
        tick(); drive(1'b1, 1'b0, 64'h80, 10'h007);
        tick(); drive(1'b0, 1'b0, '0, '0);
        chk("l4_c1_busy", 64'(busy[I4]), 64'd1);
        tick(); drive(1'b0, 1'b0, '0, '0);
        chk("l4_c2_ruser", 64'(ruser[I4]), 64'h007);
        rst_n = 1'b0;
        #1;
        chk("l4_rst_busy",  64'(busy[I4]),    64'd0);
        chk("l4_rst_vld",   64'(rvalid[I4]),  64'd0);
        chk("l4_rst_drop",  64'(drop[I4]),    64'd0);
        chk("l4_rst_ruser", 64'(ruser[I4]),   64'd0);
        chk("l4_rst_rdata", 64'(rdata[I4]),   64'd0);
        chk("l4_rst_req",   64'(mem_req[I4]), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); mem_rdata = 64'h99; drive(1'b0, 1'b0, '0, '0);
            chk("l4_post_vld",  64'(rvalid[I4]), 64'd0);
            chk("l4_post_busy", 64'(busy[I4]),   64'd0);
        end
        tick(); drive(1'b1, 1'b0, 64'h88, 10'h003);
        chk("l4_r_req", 64'(mem_req[I4]), 64'd1);
        for (int i = 1; i < 4; i++) begin
            tick(); drive(1'b0, 1'b0, '0, '0);
            chk("l4_r_wait", 64'(rvalid[I4]), 64'd0);
        end
        tick(); mem_rdata = 64'h55; drive(1'b0, 1'b0, '0, '0);
        chk("l4_r_vld",   64'(rvalid[I4]), 64'd1);
        chk("l4_r_rdata", 64'(rdata[I4]),  64'h55);
        chk("l4_r_ruser", 64'(ruser[I4]),  64'h003);

        // Latency 1: one read every two cycles, data held afterwards
        do_reset();
        tick(); drive(1'b1, 1'b0, 64'h100, 10'h02A);
        chk("l1_c0_req", 64'(mem_req[I1]), 64'd1);
        tick(); mem_rdata = 64'h77; drive(1'b0, 1'b0, '0, '0);
        chk("l1_c1_vld",   64'(rvalid[I1]), 64'd1);
        chk("l1_c1_ruser", 64'(ruser[I1]),  64'h02A);
        chk("l1_c1_rdata", 64'(rdata[I1]),  64'h77);
        tick(); mem_rdata = 64'h99; drive(1'b1, 1'b0, 64'h108, 10'h015);
        chk("l1_c2_req",  64'(mem_req[I1]), 64'd1);
        chk("l1_c2_vld",  64'(rvalid[I1]),  64'd0);
        chk("l1_c2_hold", 64'(rdata[I1]),   64'h77);
        tick(); mem_rdata = 64'hAB; drive(1'b0, 1'b0, '0, '0);
        chk("l1_c3_vld",   64'(rvalid[I1]), 64'd1);
        chk("l1_c3_rdata", 64'(rdata[I1]),  64'hAB);
        chk("l1_c3_ruser", 64'(ruser[I1]),  64'h015);
        tick(); mem_rdata = 64'hF0F0; drive(1'b0, 1'b0, '0, '0);
        chk("l1_c4_hold", 64'(rdata[I1]),   64'hAB);
        chk("l1_c4_busy", 64'(busy[I1]),    64'd0);

`ifdef MEM_WAIT_RUNTIME_LAT_EN
        // Runtime latency: 0 behaves as 1, then 5
        do_reset();
        cfg_lat[I3] = 4'd0;
        tick(); drive(1'b1, 1'b0, 64'h200, 10'h001);
        tick(); drive(1'b0, 1'b0, '0, '0);
        chk("cfg0_vld", 64'(rvalid[I3]), 64'd1);
        cfg_lat[I3] = 4'd5;
        tick(); drive(1'b1, 1'b0, 64'h208, 10'h002);
        chk("cfg5_req", 64'(mem_req[I3]), 64'd1);
        for (int i = 1; i < 5; i++) begin
            tick(); drive(1'b0, 1'b0, '0, '0);
            chk("cfg5_wait", 64'(rvalid[I3]), 64'd0);
        end
        tick(); drive(1'b0, 1'b0, '0, '0);
        chk("cfg5_vld", 64'(rvalid[I3]), 64'd1);
        cfg_lat[I3] = 4'(LATS[I3]);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_mem_wait_state_ctrl

// File: doc/mem_wait_state_ctrl.md
MEM_WAIT_STATE_CTRL -- requirements
Module: mem_wait_state_ctrl

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, data width; byte enables are AXI_DATA_WIDTH/8 wide.
REQ-003 SHALL have parameter AXI_USER_WIDTH, default 10, user width.
REQ-004 SHALL have parameter RD_LATENCY, default 2, cycles from mem request to valid mem_rdata_i; legal range 1..15.
REQ-005 SHALL have port clk_i, input, 1 bit, single clock.
REQ-006 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have ports req_i, input, 1, and we_i, input, 1: request strobe and write qualifier from the AXI adapter.
REQ-008 SHALL have ports addr_i, input, AXI_ADDR_WIDTH; be_i, input, AXI_DATA_WIDTH/8; wdata_i, input, AXI_DATA_WIDTH; user_i, input, AXI_USER_WIDTH.
REQ-009 SHALL have ports rdata_o, output, AXI_DATA_WIDTH; ruser_o, output, AXI_USER_WIDTH; rdata_valid_o, output, 1: read return to the adapter.
REQ-010 SHALL have ports busy_o, output, 1, read outstanding; drop_o, output, 1, request-dropped pulse.
REQ-011 SHALL have ports mem_req_o, mem_we_o, output, 1; mem_addr_o, output, AXI_ADDR_WIDTH; mem_be_o, output, AXI_DATA_WIDTH/8; mem_wdata_o, output, AXI_DATA_WIDTH; mem_rdata_i, input, AXI_DATA_WIDTH.

Function
REQ-012 SHALL implement FSM states IDLE and RD_WAIT.
REQ-013 In IDLE, mem_req_o SHALL equal req_i combinationally; mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o SHALL pass we_i, addr_i, be_i and wdata_i through.
REQ-014 A write (req_i=1, we_i=1) in IDLE SHALL complete in one cycle, stay in IDLE, and never assert rdata_valid_o; back-to-back writes SHALL be accepted every cycle.
REQ-015 A read (req_i=1, we_i=0) in IDLE SHALL assert mem_req_o in that cycle only, latch user_i, load the latency counter with RD_LATENCY-1, and enter RD_WAIT.
REQ-016 In RD_WAIT, mem_req_o SHALL be 0; the counter SHALL decrement each cycle while nonzero.
REQ-017 rdata_valid_o SHALL be 1 for exactly one cycle, RD_LATENCY cycles after read acceptance; in that cycle rdata_o SHALL equal mem_rdata_i and ruser_o the latched user.
REQ-018 On the rdata_valid_o cycle, the register SHALL capture mem_rdata_i, the FSM SHALL return to IDLE, and rdata_o SHALL hold the captured value until the next return.
REQ-019 With RD_LATENCY=1, rdata_valid_o SHALL fire the cycle after acceptance, and a new read SHALL be acceptable the following cycle (one read per 2 cycles).
REQ-020 busy_o SHALL be 1 exactly while in RD_WAIT.
REQ-021 Any req_i=1 in RD_WAIT, including on the rdata_valid_o cycle, SHALL be ignored (no mem_req_o) and SHALL pulse drop_o for that cycle.
REQ-022 The counter SHALL be 4 bits wide and SHALL never wrap below 0.

Reset
REQ-023 Asserting rst_ni low SHALL immediately force IDLE, counter 0, rdata_o 0, ruser_o 0, rdata_valid_o 0, busy_o 0, and drop_o 0, including mid-read; the pending read return SHALL be discarded.

Configuration
REQ-024 With MEM_WAIT_RUNTIME_LAT_EN defined, the block SHALL add input cfg_lat_i[3:0], sampled at read acceptance, which replaces RD_LATENCY; a value of 0 SHALL be treated as 1. Without the macro, the port SHALL be absent and RD_LATENCY SHALL be used.

Structure
REQ-025 The FSM state enum and the 4-bit latency-counter width constant SHALL reside in a shared package, mem_wait_pkg.
REQ-026 No sub-module is required; the counter and FSM SHALL be inline.

Verification
REQ-027 RD_LATENCY=3: read at addr 0x1000 in cycle 0, memory returns 0xDEADBEEF -> mem_req_o is high in cycle 0 only, busy_o is high in cycles 1-3, and rdata_valid_o is high in cycle 3 with rdata_o=0xDEADBEEF.
REQ-028 Four back-to-back writes at 0x0, 0x8, 0x10, 0x18 with be_i=0xFF -> four single-cycle mem_req_o/mem_we_o pulses, no rdata_valid_o, busy_o stays 0.
REQ-029 RD_LATENCY=2: read, then req_i=1 in cycle 1 -> drop_o=1 in cycle 1, no extra mem_req_o; rdata_valid_o in cycle 2; a read in cycle 3 is accepted.
REQ-030 RD_LATENCY=4: rst_ni low in cycle 2 of a read -> all outputs 0 immediately, no rdata_valid_o afterwards, and a read after reset release returns normally.
REQ-031 MEM_WAIT_RUNTIME_LAT_EN defined: cfg_lat_i=0 then 5 on successive reads -> rdata_valid_o at +1 and +5 cycles respectively.
REQ-032 RD_LATENCY=1 with user_i=0x2A -> rdata_valid_o in cycle 1 with ruser_o=0x2A; after that return, rdata_o holds its value while mem_rdata_i changes.
